// File: rtl/text_pkg.sv
// Shared constants, state encoding and debug view for the text buffer controller.
package text_pkg;

    localparam int COLS_DEF   = 80;
    localparam int ROWS_DEF   = 30;
    localparam int COL_W_DEF  = 7;
    localparam int ROW_W_DEF  = 5;
    localparam int ADDR_W_DEF = 12;

    localparam logic [7:0] CLEAR_CHAR_DEF = 8'h20;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        state_t                  state;
        logic [ADDR_W_DEF-1:0]   clr_cnt;
        logic [ROW_W_DEF-1:0]    row;
        logic [COL_W_DEF-1:0]    col;
    } dbg_t;

    function automatic logic is_printable(input logic [7:0] ch);
        return (ch >= 8'h20) && (ch <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_buffer_ctrl_if.sv
// Byte-stream handshake between a character source and the text buffer.
interface text_buffer_ctrl_if;
    // A byte transfers on every rising clk where char_valid_i and char_ready_o are
    // both high; the source holds char_i stable while valid is up and unaccepted.
    logic [7:0] char_i;
    logic       char_valid_i;
    logic       char_ready_o;
    logic       busy_o;

    modport master (output char_i, char_valid_i, input char_ready_o, busy_o);
    modport slave  (input char_i, char_valid_i, output char_ready_o, busy_o);
endinterface

// File: rtl/text_ram.sv
// Simple dual-port character RAM: one write port, one registered read port returning old data.
module text_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only the output register is reset; cell contents are initialised by the clear sweep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rdata <= 8'h00;
        else        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_buffer_ctrl.sv
// Text buffer and cursor controller: interprets an ASCII stream into an 80x30 cell RAM.
// Optional cursor outputs and blink counter are built when TXT_CURSOR_EN is defined.
module text_buffer_ctrl
    import text_pkg::*;
#(
    parameter int         COLS       = COLS_DEF,
    parameter int         ROWS       = ROWS_DEF,
    parameter int         COL_W      = COL_W_DEF,
    parameter int         ROW_W      = ROW_W_DEF,
    parameter int         ADDR_W     = ADDR_W_DEF,
    parameter logic [7:0] CLEAR_CHAR = CLEAR_CHAR_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    text_buffer_ctrl_if.slave    stream,
    input  logic [COL_W-1:0]     rd_col_i,
    input  logic [ROW_W-1:0]     rd_row_i,
    output logic [7:0]           rd_char_o,
`ifdef TXT_CURSOR_EN
    output logic [COL_W-1:0]     cursor_col_o,
    output logic [ROW_W-1:0]     cursor_row_o,
    output logic                 cursor_blink_o,
`endif
    output dbg_t                 dbg
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                    input logic [COL_W-1:0] c);
        logic [ADDR_W-1:0] rw;
        rw = ADDR_W'(r);
        if (COLS == 80) return (rw << 6) + (rw << 4) + ADDR_W'(c);
        else            return rw * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    state_t             state, state_n;
    logic [ADDR_W-1:0]  clr_cnt, clr_cnt_n;
    logic [COL_W-1:0]   col, col_n;
    logic [ROW_W-1:0]   row, row_n;
    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [7:0]         wdata;
    logic               ready, busy;
    logic               rd_oor_q;
    logic [7:0]         ram_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            col     <= '0;
            row     <= '0;
        end else begin
            state   <= state_n;
            clr_cnt <= clr_cnt_n;
            col     <= col_n;
            row     <= row_n;
        end
    end

    always_comb begin
        state_n   = state;
        clr_cnt_n = clr_cnt;
        col_n     = col;
        row_n     = row;
        we        = 1'b0;
        waddr     = cell_addr(row, col);
        wdata     = CLEAR_CHAR;
        ready     = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy  = 1'b1;
                we    = 1'b1;
                waddr = clr_cnt;
                if (clr_cnt == LAST_ADDR) begin
                    state_n   = ST_IDLE;
                    clr_cnt_n = '0;
                    col_n     = '0;
                    row_n     = '0;
                end else begin
                    clr_cnt_n = clr_cnt + 1'b1;
                end
            end
            default: begin
                ready = 1'b1;
                if (stream.char_valid_i) begin
                    if (is_printable(stream.char_i)) begin
                        we    = 1'b1;
                        wdata = stream.char_i;
                        if (col == LAST_COL) begin
                            col_n = '0;
                            row_n = (row == LAST_ROW) ? '0 : row + 1'b1;
                        end else begin
                            col_n = col + 1'b1;
                        end
                    end else begin
                        case (stream.char_i)
                            CH_CR: col_n = '0;
                            CH_LF: row_n = (row == LAST_ROW) ? '0 : row + 1'b1;
                            CH_BS: begin
                                // Backspace at the home cell has nowhere to go and writes nothing.
                                if (col != '0) begin
                                    col_n = col - 1'b1;
                                    we    = 1'b1;
                                end else if (row != '0) begin
                                    row_n = row - 1'b1;
                                    col_n = LAST_COL;
                                    we    = 1'b1;
                                end
                                waddr = cell_addr(row_n, col_n);
                            end
                            CH_FF: begin
                                state_n   = ST_CLEAR;
                                clr_cnt_n = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    assign stream.char_ready_o = ready;
    assign stream.busy_o       = busy;

    text_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (cell_addr(rd_row_i, rd_col_i)),
        .rdata (ram_rdata)
    );

    // Out-of-range indices alias into the RAM, so the flag masks them a cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_oor_q <= 1'b0;
        else        rd_oor_q <= (rd_col_i > LAST_COL) || (rd_row_i > LAST_ROW);
    end

    assign rd_char_o = rd_oor_q ? CLEAR_CHAR : ram_rdata;

`ifdef TXT_CURSOR_EN
    logic [23:0] blink_cnt;
    logic        blink;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            if (&blink_cnt) blink <= ~blink;
        end
    end

    assign cursor_col_o   = col;
    assign cursor_row_o   = row;
    assign cursor_blink_o = blink;
`endif

    assign dbg.state   = state;
    assign dbg.clr_cnt = ADDR_W_DEF'(clr_cnt);
    assign dbg.row     = ROW_W_DEF'(row);
    assign dbg.col     = COL_W_DEF'(col);

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Self-checking bench for text_buffer_ctrl: vector table, hand sequences and a random stream vs a cell-array model.
module tb_text_buffer_ctrl;
    import text_pkg::*;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] rd_col;
    logic [4:0] rd_row;
    logic [7:0] rd_char;
    dbg_t       dbg;
`ifdef TXT_CURSOR_EN
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic       cursor_blink;
`endif

    text_buffer_ctrl_if stream ();

    text_buffer_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .stream    (stream),
        .rd_col_i  (rd_col),
        .rd_row_i  (rd_row),
        .rd_char_o (rd_char),
`ifdef TXT_CURSOR_EN
        .cursor_col_o   (cursor_col),
        .cursor_row_o   (cursor_row),
        .cursor_blink_o (cursor_blink),
`endif
        .dbg       (dbg)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: screen as a flat array, cursor as a linear cell index.
    logic [7:0] exp_mem [CELLS];
    int m_row, m_col;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < CELLS; i++) exp_mem[i] = 8'h20;
        m_row = 0;
        m_col = 0;
    endfunction

    function automatic void model_apply(input logic [7:0] ch);
        int idx;
        idx = m_row * COLS + m_col;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            exp_mem[idx] = ch;
            idx = (idx + 1) % CELLS;
            m_row = idx / COLS;
            m_col = idx % COLS;
        end else if (ch == 8'h0D) begin
            m_col = 0;
        end else if (ch == 8'h0A) begin
            m_row = (m_row + 1) % ROWS;
        end else if (ch == 8'h08) begin
            if (idx != 0) begin
                idx = idx - 1;
                exp_mem[idx] = 8'h20;
                m_row = idx / COLS;
                m_col = idx % COLS;
            end
        end else if (ch == 8'h0C) begin
            model_clear();
        end
    endfunction

    task automatic send_byte(input logic [7:0] ch);
        stream.char_i       = ch;
        stream.char_valid_i = 1'b1;
        check("ready_at_send", stream.char_ready_o, 1);
        @(posedge clk);
        #1;
        stream.char_valid_i = 1'b0;
        model_apply(ch);
        if (ch != 8'h0C) begin
            check("cursor_row", dbg.row, m_row);
            check("cursor_col", dbg.col, m_col);
        end
    endtask

    task automatic read_cell(input int r, input int c, output logic [7:0] v);
        rd_row = 5'(r);
        rd_col = 7'(c);
        @(posedge clk);
        #1;
        v = rd_char;
    endtask

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (stream.busy_o === 1'b1 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, n, 2400);
        check({name, "_ready"}, stream.char_ready_o, 1);
        check({name, "_busy"}, stream.busy_o, 0);
    endtask

    typedef struct {
        logic [7:0] ch;
        int         er;
        int         ec;
        int         cr;
        int         cc;
        logic [7:0] cv;
    } vec_t;

    vec_t       vecs [14];
    logic [7:0] v;
    logic [7:0] rb;
    int         n;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{8'h0A, 1, 2,  1, 2,  8'h20};
        vecs[1]  = '{8'h0D, 1, 0,  0, 0,  8'h41};
        vecs[2]  = '{8'h01, 1, 0,  1, 0,  8'h20};
        vecs[3]  = '{8'h08, 0, 79, 0, 79, 8'h20};
        vecs[4]  = '{8'h43, 1, 0,  0, 79, 8'h43};
        vecs[5]  = '{8'h44, 1, 1,  1, 0,  8'h44};
        vecs[6]  = '{8'h08, 1, 0,  1, 0,  8'h20};
        vecs[7]  = '{8'h08, 0, 79, 0, 79, 8'h20};
        vecs[8]  = '{8'h08, 0, 78, 0, 78, 8'h20};
        vecs[9]  = '{8'h45, 0, 79, 0, 78, 8'h45};
        vecs[10] = '{8'h46, 1, 0,  0, 79, 8'h46};
        vecs[11] = '{8'h7F, 1, 0,  1, 0,  8'h20};
        vecs[12] = '{8'h7E, 1, 1,  1, 0,  8'h7E};
        vecs[13] = '{8'h1F, 1, 1,  1, 1,  8'h20};

        // Clock/reset: force a real falling edge on reset.
        reset = 1'b1;
        stream.char_i = 8'h00;
        stream.char_valid_i = 1'b0;
        rd_col = '0;
        rd_row = '0;
        #1 reset = 1'b0;
        #21;
        check("rst_busy", stream.busy_o, 1);
        check("rst_ready", stream.char_ready_o, 0);
        check("rst_rd_char", rd_char, 8'h00);
        check("rst_state", dbg.state, ST_CLEAR);
        check("rst_clr_cnt", dbg.clr_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        wait_clear("clear_after_reset");
        model_clear();
        check("cursor_home_row", dbg.row, 0);
        check("cursor_home_col", dbg.col, 0);

        read_cell(29, 79, v); check("cell_29_79", v, 8'h20);
        read_cell(30, 0, v);  check("oor_row30", v, 8'h20);
        read_cell(0, 80, v);  check("oor_col80", v, 8'h20);
        read_cell(31, 127, v); check("oor_max", v, 8'h20);

        // "AB" back to back, each read one cycle after its write.
        send_byte(8'h41);
        rd_row = 0; rd_col = 0;
        send_byte(8'h42);
        check("raw_A", rd_char, 8'h41);
        read_cell(0, 1, v); check("raw_B", v, 8'h42);
        check("ab_row", dbg.row, 0);
        check("ab_col", dbg.col, 2);

        for (int i = 0; i < 14; i++) begin
            send_byte(vecs[i].ch);
            check($sformatf("vec%0d_row", i), dbg.row, vecs[i].er);
            check($sformatf("vec%0d_col", i), dbg.col, vecs[i].ec);
            read_cell(vecs[i].cr, vecs[i].cc, v);
            check($sformatf("vec%0d_cell", i), v, vecs[i].cv);
        end

        // Same-cycle read and write of one cell returns the old byte.
        rd_row = 1; rd_col = 1;
        send_byte(8'h5A);
        check("same_cycle_old", rd_char, 8'h20);
        @(posedge clk); #1;
        check("next_cycle_new", rd_char, 8'h5A);

        send_byte(CH_FF);
        check("ff_ready_low", stream.char_ready_o, 0);
        wait_clear("clear_after_ff");
        check("ff_row", dbg.row, 0);
        check("ff_col", dbg.col, 0);
        read_cell(1, 1, v); check("ff_cell_1_1", v, 8'h20);

        for (int i = 0; i < 80; i++) send_byte(8'h58);
        send_byte(8'h59);
        for (int i = 0; i < 80; i++) begin
            read_cell(0, i, v);
            check($sformatf("row0_X_%0d", i), v, 8'h58);
        end
        read_cell(1, 0, v); check("cell_1_0_Y", v, 8'h59);

        for (int i = 0; i < 28; i++) send_byte(CH_LF);
        send_byte(CH_CR);
        check("pre_wrap_row", dbg.row, 29);
        for (int i = 0; i < 79; i++) send_byte(8'h52);
        check("at_last_col", dbg.col, 79);
        send_byte(8'h52);
        check("wrap_row", dbg.row, 0);
        check("wrap_col", dbg.col, 0);

        send_byte(CH_LF); send_byte(CH_LF);
        for (int i = 0; i < 80; i++) send_byte(8'h51 + 8'(i / 79 * 6));
        check("bs_pre_row", dbg.row, 3);
        check("bs_pre_col", dbg.col, 0);
        read_cell(2, 79, v); check("cell_2_79_W", v, 8'h57);
        send_byte(CH_BS);
        check("bs_row", dbg.row, 2);
        check("bs_col", dbg.col, 79);
        read_cell(2, 79, v); check("bs_cleared", v, 8'h20);
        send_byte(8'h57);
        for (int i = 0; i < 27; i++) send_byte(CH_LF);
        check("home_row", dbg.row, 0);
        check("home_col", dbg.col, 0);
        send_byte(CH_BS);
        check("bs_home_row", dbg.row, 0);
        check("bs_home_col", dbg.col, 0);
        read_cell(0, 0, v); check("bs_home_cell", v, 8'h58);

        send_byte(8'h61); send_byte(8'h62);
        send_byte(CH_CR); send_byte(CH_LF); send_byte(8'h01);
        check("crlf_row", dbg.row, 1);
        check("crlf_col", dbg.col, 0);

        // Reset in the middle of a clear sweep.
        send_byte(CH_FF);
        n = 0;
        while (dbg.clr_cnt != 12'd1000 && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        check("reach_cnt_1000", dbg.clr_cnt, 1000);
        reset = 1'b0;
        #1;
        check("midrst_busy", stream.busy_o, 1);
        check("midrst_ready", stream.char_ready_o, 0);
        check("midrst_rd_char", rd_char, 8'h00);
        check("midrst_cnt", dbg.clr_cnt, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_clear("clear_after_midreset");
        model_clear();

        // Random stream against the model.
        for (int i = 0; i < 600; i++) begin
            n = int'($urandom_range(0, 9));
            if (n <= 5)      rb = 8'($urandom_range(32, 126));
            else if (n == 6) rb = CH_CR;
            else if (n == 7) rb = CH_LF;
            else if (n == 8) rb = CH_BS;
            else begin
                rb = 8'($urandom_range(0, 255));
                if (rb == CH_FF) rb = 8'h01;
            end
            send_byte(rb);
        end
        for (int i = 0; i < CELLS; i++) begin
            read_cell(i / COLS, i % COLS, v);
            check($sformatf("sweep_%0d_%0d", i / COLS, i % COLS), v, exp_mem[i]);
        end

`ifdef TXT_CURSOR_EN
        check("cursor_out_col", cursor_col, m_col);
        check("cursor_out_row", cursor_row, m_row);
        check("cursor_blink", cursor_blink, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/text_buffer_ctrl.md
Name: text_buffer_ctrl

Overview:
- Character-cell text buffer and cursor controller feeding the VGA text generator stage.
- Accepts an ASCII byte stream over a valid/ready handshake and interprets control codes.
- Stores the screen contents in an internal dual-port character RAM, 80x30 cells (640x480 with 8x16 glyphs).
- The text generator reads the RAM through an independent read port addressed by character column/row.

Parameters:
- COLS, 80, characters per row.
- ROWS, 30, character rows.
- COL_W, 7, column index width.
- ROW_W, 5, row index width.
- ADDR_W, 12, RAM address width; must satisfy 2^ADDR_W >= COLS*ROWS.
- CLEAR_CHAR, 8'h20, fill code used by clear and backspace.

Ports:
- clk  in  1  system clock (same domain as the text generator).
- reset  in  1  asynchronous, active-low reset.
- char_i  in  8  ASCII byte to write.
- char_valid_i  in  1  char_i valid.
- char_ready_o  out  1  block can accept char_i this cycle.
- busy_o  out  1  clear sequence in progress.
- rd_col_i  in  COL_W  read column from the text generator.
- rd_row_i  in  ROW_W  read row from the text generator.
- rd_char_o  out  8  cell contents at (rd_row_i, rd_col_i), registered.

Behaviour:
- Reset (reset=0), asynchronous:
  - state=CLEAR, clear counter=0, cursor=(0,0).
  - char_ready_o=0, busy_o=1, rd_char_o=8'h00.
  - RAM contents are not reset; the CLEAR state initialises them.
- FSM states:
  - IDLE: char_ready_o=1, busy_o=0.
  - CLEAR: char_ready_o=0, busy_o=1. Writes CLEAR_CHAR to address clr_cnt each cycle, incrementing clr_cnt from 0 to COLS*ROWS-1. At the last address it goes to IDLE with cursor=(0,0). Duration is exactly COLS*ROWS cycles (2400 at defaults).
- Accept: char_valid_i & char_ready_o. At most one byte per cycle, no bubbles in IDLE.
- Byte handling on accept:
  - 0x20..0x7E: write to addr = row*COLS+col, then advance the cursor.
  - Advance: col=COLS-1 wraps to col 0, row+1. At (ROWS-1, COLS-1) the cursor wraps to (0,0). There is no scrolling.
  - 0x0D (CR): col=0, no write.
  - 0x0A (LF): row+1, wrapping ROWS-1 -> 0; col unchanged; no write.
  - 0x08 (BS): move back one cell and write CLEAR_CHAR there. At col 0 it moves to (row-1, COLS-1). At (0,0) it is a no-op.
  - 0x0C (FF): enter CLEAR the next cycle.
  - Any other code: accepted and discarded; cursor unchanged.
- Address arithmetic is unsigned. row*COLS is computed as (row<<6)+(row<<4) when COLS=80; a generic multiply is used otherwise. Result width is ADDR_W.
- Read port:
  - Always active, including during CLEAR.
  - rd_char_o is valid 1 cycle after rd_col_i/rd_row_i are presented.
  - Out-of-range indices return CLEAR_CHAR.
  - Read and write to the same address in the same cycle returns the old data. New data is visible on a read issued the cycle after the write.
- Reset asserted mid-CLEAR or mid-stream restarts CLEAR from address 0.

Optional Feature:
- Macro: TXT_CURSOR_EN.
- Defined:
  - Adds outputs cursor_col_o[COL_W-1:0], cursor_row_o[ROW_W-1:0] and cursor_blink_o.
  - cursor_blink_o toggles every 2^24 clk cycles from a free-running counter; reset value 0.
  - The text generator inverts the cell at the cursor while cursor_blink_o=1.
- Undefined: these ports and the counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package text_pkg:
  - COLS/ROWS defaults.
  - Control-code constants CH_CR, CH_LF, CH_BS, CH_FF.
  - State encoding ST_IDLE, ST_CLEAR.
  - CLEAR_CHAR default.
- One sub-module: text_ram, a simple dual-port RAM (1 write, 1 registered read, read-old-data semantics) sized 2^ADDR_W x 8.

Test Plan:
- Release reset -> busy_o=1 for exactly 2400 cycles, then char_ready_o=1. Reading any cell (e.g. row 29, col 79) returns 8'h20.
- Send "AB" back-to-back after clear -> cell (0,0)=0x41, (0,1)=0x42, cursor=(0,2). Reads issued one cycle after each write return the new byte.
- Send 80 x 'X' then 'Y' -> row 0 all 0x58, (1,0)=0x59. Cursor at (29,79) plus one printable -> cursor (0,0).
- Cursor at (3,0): send BS -> cursor (2,79), cell (2,79)=0x20. At (0,0), BS changes nothing.
- Send CR, LF, 0x01 -> col=0, then row+1, then no change. All three accepted with char_ready_o held at 1.
- Send FF mid-stream -> char_ready_o=0 for 2400 cycles, all cells 0x20, cursor (0,0). Assert reset at clear count 1000 -> clear restarts at 0 and busy_o lasts a full 2400 cycles after release.
